// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: word/strobe widths, FSM states, captured request.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = 4;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } req_t;

  function automatic logic [ADDR_W-3:0] word_index(input logic [ADDR_W-1:0] byte_addr);
    return byte_addr[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/dmem_storage_array.sv
// Word-addressed storage: synchronous byte-masked write, asynchronous read, contents never reset.
module dmem_storage_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [STRB_W-1:0] strb,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (strb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder: accept, wait LATENCY cycles, commit, hold response.
// Optional DMEM_MISALIGN_CHECK_EN faults accesses whose byte address is not word aligned.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic              i_reqValid,
  output logic              o_reqReady,
  input  logic              i_reqWrite,
  input  logic [ADDR_W-1:0] i_reqAddr,
  input  logic [WORD_W-1:0] i_reqWdata,
  input  logic [STRB_W-1:0] i_reqStrb,
  output logic              o_rspValid,
  input  logic              i_rspReady,
  output logic [WORD_W-1:0] o_rspRdata,
  output logic              o_rspErr
);

  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY);

  state_t            state;
  state_t            state_nxt;
  req_t              req;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] rdata;
  logic              err;

  logic              accept;
  logic              commit;
  logic              rsp_done;
  logic              range_fault;
  logic              align_fault;
  logic              fault;
  logic              mem_we;
  logic [ADDR_W-3:0] widx;
  logic [WORD_W-1:0] mem_rdata;

  assign accept   = i_reqValid && o_reqReady;
  assign commit   = (state == WAIT) && (cnt == '0);
  assign rsp_done = o_rspValid && i_rspReady;

  // Range check on the full 30-bit word index, so high addresses fault instead of aliasing.
  assign widx        = word_index(req.addr);
  assign range_fault = ({2'b00, widx} >= ADDR_W'(DEPTH_WORDS));

`ifdef DMEM_MISALIGN_CHECK_EN
  assign align_fault = |req.addr[1:0];
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req.addr[1:0];
  assign align_fault     = 1'b0;
`endif

  assign fault = range_fault || align_fault;

  // A reset landing on the commit edge must not let the store through.
  assign mem_we = commit && req.write && !fault && i_srst;

  dmem_storage_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_storage (
    .clk   (i_clk),
    .wr_en (mem_we),
    .addr  (widx[AW-1:0]),
    .wdata (req.wdata),
    .strb  (req.strb),
    .rdata (mem_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (!i_srst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    o_reqReady = 1'b0;
    o_rspValid = 1'b0;
    case (state)
      IDLE: begin
        o_reqReady = 1'b1;
        if (i_reqValid) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        o_rspValid = 1'b1;
        if (i_rspReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_srst) begin
      req   <= '0;
      cnt   <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      if (accept) begin
        req <= '{write: i_reqWrite, addr: i_reqAddr, wdata: i_reqWdata, strb: i_reqStrb};
        cnt <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (commit) begin
        err   <= fault;
        rdata <= (fault || req.write) ? '0 : mem_rdata;
      end else if (rsp_done) begin
        err   <= 1'b0;
        rdata <= '0;
      end
    end
  end

  assign o_rspRdata = rdata;
  assign o_rspErr   = err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed cases, backpressure, reset in WAIT, random mix.
module tb_data_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic        clk;
  logic        srst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [DEPTH];
  bit          written [DEPTH];
  int          checks = 0;
  int          errors = 0;

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) u_dut (
    .i_clk      (clk),
    .i_srst     (srst),
    .i_reqValid (req_valid),
    .o_reqReady (req_ready),
    .i_reqWrite (req_write),
    .i_reqAddr  (req_addr),
    .i_reqWdata (req_wdata),
    .i_reqStrb  (req_strb),
    .o_rspValid (rsp_valid),
    .i_rspReady (rsp_ready),
    .o_rspRdata (rsp_rdata),
    .o_rspErr   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic addr_fault(input logic [31:0] a);
    logic f;
    f = (a[31:2] >= 30'(DEPTH));
`ifdef DMEM_MISALIGN_CHECK_EN
    f = f || (a[1:0] != 2'b00);
`endif
    return f;
  endfunction

  // Drive one request, then check latency, response payload, stability under backpressure and release.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp_rdata, input logic exp_err,
                        input int hold);
    int   lat;
    exp_t e;
    @(negedge clk);
    check_val("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < LAT + 20) begin
      @(negedge clk);
      lat++;
    end
    check_val("rsp_latency", 32'(lat), 32'(LAT + 1));
    e = exp_q.pop_front();
    check_val("rsp_rdata", rsp_rdata, e.rdata);
    check_val("rsp_err", 32'(rsp_err), 32'(e.err));
    check_val("req_ready_busy", 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h10;
      req_wdata = 32'hBAD0BAD0;
      req_strb  = 4'hF;
      @(negedge clk);
      check_val("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check_val("hold_rdata", rsp_rdata, e.rdata);
      check_val("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_val("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("post_rdata", rsp_rdata, 32'd0);
    check_val("post_err", 32'(rsp_err), 32'd0);
    check_val("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                       input logic exp_err);
    int idx;
    do_req(1'b1, addr, wdata, strb, 32'd0, exp_err, 0);
    if (!addr_fault(addr)) begin
      idx = int'(addr[31:2]);
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
      end
      if (strb == 4'hF) written[idx] = 1'b1;
    end
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] exp_rdata, input logic exp_err,
                      input int hold);
    do_req(1'b0, addr, 32'd0, 4'h0, exp_rdata, exp_err, hold);
  endtask

  initial begin
    srst      = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;

    repeat (3) @(negedge clk);
    check_val("rst_req_ready", 32'(req_ready), 32'd1);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rdata", rsp_rdata, 32'd0);
    check_val("rst_err", 32'(rsp_err), 32'd0);
    srst = 1'b1;

    store(32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    load(32'h10, 32'hDEADBEEF, 1'b0, 0);
    store(32'h10, 32'h11223344, 4'b0101, 1'b0);
    load(32'h10, 32'hDE22BE44, 1'b0, 0);

    store(32'h0, 32'hCAFEF00D, 4'hF, 1'b0);
    load(32'h400, 32'd0, 1'b1, 0);
    store(32'h400, 32'h55555555, 4'hF, 1'b1);
    load(32'h0, 32'hCAFEF00D, 1'b0, 0);
    load(32'hFFFFFFFC, 32'd0, 1'b1, 0);

    store(32'h14, 32'h01020304, 4'hF, 1'b0);
    store(32'h14, 32'hFFFFFFFF, 4'h0, 1'b0);
    load(32'h14, 32'h01020304, 1'b0, 0);

    // Backpressure with a competing store presented the whole time; it must be ignored.
    load(32'h10, 32'hDE22BE44, 1'b0, 10);
    load(32'h10, 32'hDE22BE44, 1'b0, 0);

`ifdef DMEM_MISALIGN_CHECK_EN
    load(32'h12, 32'd0, 1'b1, 0);
`else
    load(32'h12, 32'hDE22BE44, 1'b0, 0);
`endif

    // Reset arriving on the commit edge of a store drops it.
    store(32'h20, 32'hAAAA5555, 4'hF, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    req_strb  = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("wait_req_ready", 32'(req_ready), 32'd0);
    srst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    srst = 1'b1;
    check_val("midrst_req_ready", 32'(req_ready), 32'd1);
    check_val("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    load(32'h20, 32'hAAAA5555, 1'b0, 0);

    for (int n = 0; n < 24; n++) begin
      int          idx;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      idx = 64 + $urandom_range(0, 7);
      a   = 32'(idx) << 2;
      if (written[idx] && $urandom_range(0, 1) == 1) begin
        load(a, model[idx], 1'b0, $urandom_range(0, 2));
      end else begin
        d = $urandom;
        s = written[idx] ? 4'($urandom_range(0, 15)) : 4'hF;
        store(a, d, s, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
